// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: sequential fetch, redirects, trap entry/return,
// stalls and debug halt. Define PC_SEQ_MISALIGN_CHECK_EN to trap on misaligned branch targets.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_current,
    input  logic        stall_hazard,
    input  logic        imem_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        trap_req,
    input  logic [31:0] trap_pc,
    input  logic [3:0]  trap_cause,
    input  logic        mret,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc_next,
    output logic        pc_write_enable,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] epc,
    output logic [3:0]  cause,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  drain_q, drain_d;
    logic [31:0] epc_q, epc_d;
    logic [3:0]  cause_q, cause_d;
    logic        halted_q;
    logic        flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BOOT;
            drain_q  <= 4'd0;
            epc_q    <= 32'd0;
            cause_q  <= 4'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            halted_q <= (state_d == ST_HALT);
        end
    end

    always_comb begin
        state_d         = state_q;
        drain_d         = drain_q;
        epc_d           = epc_q;
        cause_d         = cause_q;
        pc_next         = pc_current;
        pc_write_enable = 1'b0;
        flush           = 1'b0;

        case (state_q)
            ST_BOOT: begin
                pc_next         = RESET_VECTOR;
                pc_write_enable = 1'b1;
                flush           = 1'b1;
                state_d         = ST_RUN;
            end
            ST_RUN: begin
                if (trap_req) begin
                    pc_next         = TRAP_VECTOR;
                    pc_write_enable = 1'b1;
                    flush           = 1'b1;
                    epc_d           = trap_pc;
                    cause_d         = trap_cause;
                    drain_d         = DRAIN_LOAD;
                    state_d         = ST_DRAIN;
                end else if (mret) begin
                    pc_next         = epc_q;
                    pc_write_enable = 1'b1;
                    flush           = 1'b1;
                end else if (branch_taken) begin
`ifdef PC_SEQ_MISALIGN_CHECK_EN
                    // A misaligned redirect becomes a trap reporting the bad target.
                    if (branch_target[1:0] != 2'b00) begin
                        pc_next         = TRAP_VECTOR;
                        pc_write_enable = 1'b1;
                        flush           = 1'b1;
                        epc_d           = branch_target;
                        cause_d         = 4'd0;
                        drain_d         = DRAIN_LOAD;
                        state_d         = ST_DRAIN;
                    end else begin
                        pc_next         = branch_target;
                        pc_write_enable = 1'b1;
                        flush           = 1'b1;
                    end
`else
                    pc_next         = branch_target;
                    pc_write_enable = 1'b1;
                    flush           = 1'b1;
`endif
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (stall_hazard || !imem_ready) begin
                    pc_next = pc_current;
                end else begin
                    pc_next         = pc_current + 32'd4;
                    pc_write_enable = 1'b1;
                end
            end
            ST_DRAIN: begin
                flush   = 1'b1;
                drain_d = drain_q - 4'd1;
                if (drain_q <= 4'd1) begin
                    drain_d = 4'd0;
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign flush_if_id = flush;
    assign flush_id_ex = flush;
    assign epc         = epc_q;
    assign cause       = cause_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural fetch-controller model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          DC = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_current;
    logic        stall_hazard, imem_ready, branch_taken, trap_req, mret, halt_req, resume;
    logic [31:0] branch_target, trap_pc;
    logic [3:0]  trap_cause;
    logic [31:0] pc_next, epc;
    logic        pc_write_enable, flush_if_id, flush_id_ex, halted;
    logic [3:0]  cause;

    int n_checks = 0;
    int n_fail   = 0;

    // Write-side of the PC register as seen at the previous falling edge.
    logic        s_we;
    logic [31:0] s_pc_next;

    pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .pc_current(pc_current),
        .stall_hazard(stall_hazard), .imem_ready(imem_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret(mret), .halt_req(halt_req), .resume(resume),
        .pc_next(pc_next), .pc_write_enable(pc_write_enable),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .epc(epc), .cause(cause), .halted(halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending boot write, remaining drain cycles, halt flag, trap registers.
    bit          m_boot = 1'b1;
    int          m_drain = 0;
    bit          m_halt = 1'b0;
    logic [31:0] m_epc = 32'd0;
    logic [3:0]  m_cause = 4'd0;

    initial begin
        bit          nb, nh, e_we, e_fl, chk_pc;
        int          nd;
        logic [31:0] ne, e_pc;
        logic [3:0]  nc;
        forever begin
            @(negedge clk);
            nb = 1'b0; nd = m_drain; nh = m_halt; ne = m_epc; nc = m_cause;
            e_pc = pc_current; e_we = 1'b0; e_fl = 1'b0; chk_pc = 1'b1;
            if (!rst_n) begin
                e_pc = RV; e_we = 1'b1; e_fl = 1'b1;
                chk("rst_epc", epc, 32'd0);
                chk("rst_cause", {28'd0, cause}, 32'd0);
                chk("rst_halted", {31'd0, halted}, 32'd0);
            end else begin
                chk("epc", epc, m_epc);
                chk("cause", {28'd0, cause}, {28'd0, m_cause});
                chk("halted", {31'd0, halted}, {31'd0, m_halt});
                if (m_boot) begin
                    e_pc = RV; e_we = 1'b1; e_fl = 1'b1;
                end else if (m_drain > 0) begin
                    e_fl = 1'b1; nd = m_drain - 1;
                end else if (m_halt) begin
                    chk_pc = 1'b0;
                    if (resume) nh = 1'b0;
                end else if (trap_req) begin
                    e_pc = TV; e_we = 1'b1; e_fl = 1'b1;
                    ne = trap_pc; nc = trap_cause; nd = DC;
                end else if (mret) begin
                    e_pc = m_epc; e_we = 1'b1; e_fl = 1'b1;
                end else if (branch_taken) begin
                    e_pc = branch_target; e_we = 1'b1; e_fl = 1'b1;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
                    if (branch_target % 4 != 0) begin
                        e_pc = TV; ne = branch_target; nc = 4'd0; nd = DC;
                    end
`endif
                end else if (halt_req) begin
                    chk_pc = 1'b0; nh = 1'b1;
                end else if (stall_hazard || !imem_ready) begin
                    e_pc = pc_current;
                end else begin
                    e_pc = pc_current + 32'd4; e_we = 1'b1;
                end
            end
            if (chk_pc) chk("pc_next", pc_next, e_pc);
            chk("we", {31'd0, pc_write_enable}, {31'd0, e_we});
            chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, e_fl});
            chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, e_fl});
            s_we = pc_write_enable;
            s_pc_next = pc_next;
            @(posedge clk);
            if (!rst_n) begin
                m_boot = 1'b1; m_drain = 0; m_halt = 1'b0; m_epc = 32'd0; m_cause = 4'd0;
            end else begin
                m_boot = nb; m_drain = nd; m_halt = nh; m_epc = ne; m_cause = nc;
            end
        end
    end

    // Advance one cycle: the PC register loads on the edge, inputs change 1 ns later.
    task automatic cyc();
        @(posedge clk);
        if (rst_n && s_we) pc_current = s_pc_next;
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        stall_hazard = 0; imem_ready = 1; branch_taken = 0; trap_req = 0;
        mret = 0; halt_req = 0; resume = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; pc_current = 32'hDEAD_0000;
        branch_target = 0; trap_pc = 0; trap_cause = 0;
        s_we = 0; s_pc_next = 0;
        idle();
        #1 rst_n = 1'b0;
        repeat (3) cyc();
        at_neg();
        chk("lit_rst_halted", {31'd0, halted}, 32'd0);
        cyc(); rst_n = 1'b1;
        at_neg();
        chk("lit_boot_pc", pc_next, 32'h0);
        chk("lit_boot_flush", {31'd0, flush_if_id}, 32'd1);
        cyc(); at_neg(); chk("lit_seq4", pc_next, 32'h4);
        cyc(); at_neg(); chk("lit_seq8", pc_next, 32'h8);
        cyc(); at_neg(); chk("lit_seqC", pc_next, 32'hC);

        // Hazard stall for three cycles, then a branch that overrides the stall.
        cyc(); pc_current = 32'h20; stall_hazard = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            at_neg();
            chk("lit_stall_we", {31'd0, pc_write_enable}, 32'd0);
            chk("lit_stall_pc", pc_next, 32'h20);
        end
        cyc(); branch_taken = 1; branch_target = 32'h80;
        at_neg(); chk("lit_br_pc", pc_next, 32'h80);
        chk("lit_br_flush", {31'd0, flush_id_ex}, 32'd1);
        cyc(); idle();

        // Trap entry, drain, then mret.
        cyc(); trap_req = 1; trap_pc = 32'h44; trap_cause = 4'hB;
        at_neg(); chk("lit_trap_pc", pc_next, 32'h100);
        cyc(); idle();
        at_neg(); chk("lit_drain_we", {31'd0, pc_write_enable}, 32'd0);
        chk("lit_epc", epc, 32'h44);
        chk("lit_cause", {28'd0, cause}, 32'hB);
        cyc(); at_neg(); chk("lit_drain2_fl", {31'd0, flush_if_id}, 32'd1);
        cyc(); at_neg(); chk("lit_after_drain", pc_next, 32'h104);
        cyc(); mret = 1;
        at_neg(); chk("lit_mret_pc", pc_next, 32'h44);
        cyc(); idle();

        // Trap and branch together; a branch during the drain is ignored.
        cyc(); trap_req = 1; trap_pc = 32'h60; trap_cause = 4'h2;
        branch_taken = 1; branch_target = 32'h200;
        at_neg(); chk("lit_trap_vs_br", pc_next, 32'h100);
        cyc(); trap_req = 0;
        at_neg(); chk("lit_epc_trap_pc", epc, 32'h60);
        chk("lit_drain_br_we", {31'd0, pc_write_enable}, 32'd0);
        cyc(); idle(); cyc();

        // Debug halt, ignored requests while halted, resume.
        cyc(); pc_current = 32'h30; halt_req = 1;
        at_neg(); chk("lit_halt_we", {31'd0, pc_write_enable}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(); halt_req = 0; trap_req = (i == 1); branch_taken = (i == 2);
            at_neg(); chk("lit_halted", {31'd0, halted}, 32'd1);
        end
        cyc(); idle(); resume = 1;
        cyc(); resume = 0;
        at_neg(); chk("lit_resume_pc", pc_next, 32'h34);
        chk("lit_resume_we", {31'd0, pc_write_enable}, 32'd1);

        // Reset while halted.
        cyc(); halt_req = 1;
        cyc(); halt_req = 0;
        at_neg(); rst_n = 1'b0;
        #1 chk("lit_rst_mid_halt", {31'd0, halted}, 32'd0);
        cyc(); cyc(); rst_n = 1'b1;
        at_neg(); chk("lit_reboot_pc", pc_next, RV);
        cyc();

        // Misaligned branch target.
        cyc(); branch_taken = 1; branch_target = 32'h102;
        at_neg();
`ifdef PC_SEQ_MISALIGN_CHECK_EN
        chk("lit_misalign_pc", pc_next, 32'h100);
        cyc(); idle();
        at_neg(); chk("lit_misalign_epc", epc, 32'h102);
        chk("lit_misalign_cause", {28'd0, cause}, 32'd0);
`else
        chk("lit_misalign_pc", pc_next, 32'h102);
        cyc(); idle();
`endif
        repeat (3) cyc();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            trap_req      = ($urandom % 16) == 0;
            trap_pc       = $urandom;
            trap_cause    = 4'($urandom);
            mret          = ($urandom % 20) == 0;
            branch_taken  = ($urandom % 8) == 0;
            branch_target = (($urandom % 8) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            halt_req      = ($urandom % 40) == 0;
            resume        = ($urandom % 6) == 0;
            stall_hazard  = ($urandom % 5) == 0;
            imem_ready    = ($urandom % 6) != 0;
            if (($urandom % 50) == 0) pc_current = 32'hFFFF_FFFC;
        end
        cyc(); idle();
        repeat (4) cyc();
        at_neg();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the fetch stage. Drives `pc_next` and `pc_write_enable` into the program counter register.
- Arbitrates between sequential fetch, branch/jump redirect, trap entry, trap return (mret), hazard stalls, instruction-memory wait and debug halt.
- Generates IF/ID and ID/EX flush strobes.
- Holds trap state: saved exception PC and cause.

Parameters:
- RESET_VECTOR, 32'h00000000, first PC written after reset release.
- TRAP_VECTOR, 32'h00000100, trap handler entry address.
- DRAIN_CYCLES, 2, cycles of pipeline flush after trap entry (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_current  in  32  PC register output.
- stall_hazard  in  1  load-use stall request from hazard unit.
- imem_ready  in  1  instruction memory has returned the current fetch.
- branch_taken  in  1  EX-stage redirect valid.
- branch_target  in  32  EX-stage redirect address.
- trap_req  in  1  exception/ecall request, single-cycle pulse.
- trap_pc  in  32  PC of the faulting instruction.
- trap_cause  in  4  cause code.
- mret  in  1  return-from-trap request.
- halt_req  in  1  debug halt request.
- resume  in  1  debug resume pulse.
- pc_next  out  32  next PC to the PC register.
- pc_write_enable  out  1  PC register load enable.
- flush_if_id  out  1  squash the IF/ID register.
- flush_id_ex  out  1  squash the ID/EX register.
- epc  out  32  saved trap PC (registered).
- cause  out  4  saved trap cause (registered).
- halted  out  1  high while in HALT.

Behaviour:
- States: BOOT, RUN, DRAIN, HALT. `pc_next`, `pc_write_enable` and the flushes are combinational from state and inputs. `epc`, `cause`, `halted`, state and drain counter are registered.
- Reset (rst_n=0, asynchronous):
  - state=BOOT, drain counter=0, epc=0, cause=0, halted=0.
  - Combinational outputs while in BOOT: pc_next=RESET_VECTOR, pc_write_enable=1, flushes=1.
- BOOT: one cycle, writes RESET_VECTOR, then goes to RUN unconditionally.
- RUN, evaluated in fixed priority (highest first):
  1. trap_req: pc_next=TRAP_VECTOR, we=1, both flushes=1. Capture epc<=trap_pc and cause<=trap_cause. Load counter=DRAIN_CYCLES and go to DRAIN.
  2. mret: pc_next=epc, we=1, both flushes=1. Stay in RUN.
  3. branch_taken: pc_next=branch_target, we=1, both flushes=1. Overrides stall_hazard and imem_ready=0.
  4. halt_req: we=0, no flush, go to HALT.
  5. stall_hazard or !imem_ready: we=0, pc_next=pc_current, no flush.
  6. Otherwise: pc_next=pc_current+32'd4 (modulo 2^32; 32'hFFFFFFFC wraps to 0), we=1.
- DRAIN:
  - we=0, pc_next=pc_current, both flushes=1.
  - Counter decrements each cycle; at 1, return to RUN.
  - trap_req, mret, branch_taken and halt_req are ignored.
  - A trap_req arriving in DRAIN is dropped; the trap source must re-assert it.
- HALT:
  - we=0, flushes=0, halted=1.
  - resume returns to RUN next cycle, with fetch continuing from the unchanged pc_current.
  - trap_req and branch_taken are ignored. halt_req is level-insensitive once halted.
- Simultaneous events resolve by the RUN priority list above. A trap in the same cycle as a branch takes the trap, and epc=trap_pc.
- Reset asserted mid-DRAIN or mid-HALT aborts immediately to BOOT.
- `epc` changes only on trap entry. mret with no prior trap returns to 0.

Optional Feature:
- Macro: PC_SEQ_MISALIGN_CHECK_EN.
- Enabled:
  - In RUN, a branch_taken with branch_target[1:0]!=0 (and no higher-priority trap_req) is treated as a trap.
  - Target pc_next=TRAP_VECTOR, epc=branch_target, cause=4'd0. Flushes and DRAIN proceed as a normal trap.
- Disabled: branch targets are used unchanged; no alignment check logic exists.

Test Plan:
- Reset then release -> cycle 1: pc_next=0x0, we=1, flushes=1. Then in RUN with pc_current incrementing 0x0, 0x4, 0x8, ...: pc_next=0x4, 0x8, 0xC and we=1 each cycle.
- pc_current=0x20, stall_hazard=1 for 3 cycles -> we=0 for 3 cycles and pc_next=0x20. Same cycle with branch_taken=1, target=0x80 -> pc_next=0x80, we=1, both flushes=1.
- trap_req with trap_pc=0x44, cause=0xB, DRAIN_CYCLES=2 -> pc_next=0x100, we=1. Then 2 cycles of we=0 with flushes=1; epc=0x44, cause=0xB. A later mret -> pc_next=0x44, flushes=1.
- trap_req and branch_taken (0x200) in the same cycle -> pc_next=0x100, epc=trap_pc. A branch_taken during DRAIN -> ignored.
- halt_req at pc_current=0x30 -> halted=1, we=0 for 5 cycles. resume -> next cycle pc_next=0x34, we=1. rst_n pulsed low while halted -> halted=0 immediately, BOOT on release.
- With PC_SEQ_MISALIGN_CHECK_EN: branch_target=0x102 -> pc_next=0x100, epc=0x102, cause=0. Without the macro -> pc_next=0x102.
